// File: rtl/reg_file.sv
// Register file with two combinational read ports, one write port and a
// per-register pending scoreboard. Optional same-cycle write bypass: REGFILE_BYPASS_EN.
module reg_file #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        rs1_addr,
  input  logic [ADDR_W-1:0]        rs2_addr,
  output logic signed [WIDTH-1:0]  bus_a,
  output logic signed [WIDTH-1:0]  bus_b,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     stall
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;

  logic             wr_en;
  logic             rsv_en;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             pend_a;
  logic             pend_b;

  assign wr_en  = reg_write && (rd_addr != '0);
  assign rsv_en = rsv_valid && (rsv_addr != '0);

  // Array and scoreboard update; the reservation is applied last so it wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else begin
      if (wr_en) begin
        regs[rd_addr]    <= wr_data;
        pending[rd_addr] <= 1'b0;
      end
      if (rsv_en) begin
        pending[rsv_addr] <= 1'b1;
      end
    end
  end

  // Read ports and stall; x0 is forced to zero and never pending.
  always_comb begin
    rd_a   = regs[rs1_addr];
    rd_b   = regs[rs2_addr];
    pend_a = pending[rs1_addr];
    pend_b = pending[rs2_addr];
    if (rs1_addr == '0) begin
      rd_a   = '0;
      pend_a = 1'b0;
    end
    if (rs2_addr == '0) begin
      rd_b   = '0;
      pend_b = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    // A source matching this cycle's write sees the new data and is no longer waiting.
    if (wr_en && (rs1_addr == rd_addr)) begin
      rd_a   = wr_data;
      pend_a = 1'b0;
    end
    if (wr_en && (rs2_addr == rd_addr)) begin
      rd_b   = wr_data;
      pend_b = 1'b0;
    end
`endif
  end

  assign bus_a = rd_a;
  assign bus_b = rd_b;
  assign stall = pend_a | pend_b;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table plus randomized
// traffic compared against an array/scoreboard model.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [WIDTH-1:0]  bus_a;
  logic [WIDTH-1:0]  bus_b;
  logic              reg_write;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic              stall;

  reg_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .bus_a     (bus_a),
    .bus_b     (bus_b),
    .reg_write (reg_write),
    .rd_addr   (rd_addr),
    .wr_data   (wr_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: architectural register contents and outstanding reservations.
  logic [WIDTH-1:0] m_mem  [DEPTH];
  bit               m_pend [DEPTH];

  typedef struct {
    logic             r;
    logic             w;
    logic [4:0]       rd;
    logic [31:0]      wd;
    logic             v;
    logic [4:0]       ra;
    logic [4:0]       s1;
    logic [4:0]       s2;
    logic [31:0]      ea;
    logic [31:0]      eb;
    logic             es;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [WIDTH-1:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (BYP && reg_write && rd_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit m_waiting(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (BYP && reg_write && rd_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic drive(input logic r, input logic w, input logic [4:0] d, input logic [31:0] data,
                       input logic v, input logic [4:0] ra, input logic [4:0] s1, input logic [4:0] s2);
    rst       = r;
    reg_write = w;
    rd_addr   = d;
    wr_data   = data;
    rsv_valid = v;
    rsv_addr  = ra;
    rs1_addr  = s1;
    rs2_addr  = s2;
    #2;
  endtask

  // Advance one clock, applying the architectural effect of the current inputs to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (reg_write && rd_addr != 5'd0) begin
        m_mem[rd_addr]  = wr_data;
        m_pend[rd_addr] = 1'b0;
      end
      if (rsv_valid && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  initial begin
    // Directed vectors: {rst, we, rd, wd, rsv, ra, rs1, rs2, exp_a, exp_b, exp_stall}
    tbl.push_back('{0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5, BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0});
    tbl.push_back('{0, 1, 0, 32'h12345678, 1, 0, 0, 5, 32'h0, 32'hDEADBEEF, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0, 32'h0, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        1, 7, 0, 7, 32'h0, 32'h0, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 7, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 1, 7, 32'h55,       0, 0, 0, 7, 32'h0, BYP ? 32'h55 : 32'h0, BYP ? 1'b0 : 1'b1});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 7, 32'h0, 32'h55, 0});
    tbl.push_back('{0, 1, 9, 32'hA5,       1, 9, 9, 0, BYP ? 32'hA5 : 32'h0, 32'h0, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 9, 0, 32'hA5, 32'h0, 1});
    tbl.push_back('{0, 0, 0, 32'h0,        1, 9, 9, 0, 32'hA5, 32'h0, 1});
    tbl.push_back('{0, 1, 9, 32'hB6,       0, 0, 9, 9, BYP ? 32'hB6 : 32'hA5, BYP ? 32'hB6 : 32'hA5, BYP ? 1'b0 : 1'b1});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 9, 9, 32'hB6, 32'hB6, 0});
    tbl.push_back('{0, 1, 3, 32'h77,       0, 0, 0, 0, 32'h0, 32'h0, 0});
    tbl.push_back('{0, 1, 3, 32'h1,        0, 0, 3, 0, BYP ? 32'h1 : 32'h77, 32'h0, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 3, 3, 32'h1, 32'h1, 0});
    tbl.push_back('{1, 1, 4, 32'h99,       1, 4, 9, 3, 32'hB6, 32'h1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 9, 4, 32'h0, 32'h0, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        1, 10, 10, 0, 32'h0, 32'h0, 0});
    tbl.push_back('{1, 0, 0, 32'h0,        0, 0, 10, 0, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 10, 0, 32'h0, 32'h0, 0});
    tbl.push_back('{0, 1, 10, 32'h42,      0, 0, 10, 0, BYP ? 32'h42 : 32'h0, 32'h0, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 10, 10, 32'h42, 32'h42, 0});

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Every index reads zero and idle right after reset.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(DEPTH - 1 - i));
      check($sformatf("rst_a[%0d]", i), bus_a, 32'h0);
      check($sformatf("rst_b[%0d]", DEPTH - 1 - i), bus_b, 32'h0);
      check($sformatf("rst_stall[%0d]", i), {31'h0, stall}, 32'h0);
      tick();
    end

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].r, tbl[k].w, tbl[k].rd, tbl[k].wd, tbl[k].v, tbl[k].ra, tbl[k].s1, tbl[k].s2);
      check($sformatf("vec%0d bus_a", k), bus_a, tbl[k].ea);
      check($sformatf("vec%0d bus_b", k), bus_b, tbl[k].eb);
      check($sformatf("vec%0d stall", k), {31'h0, stall}, {31'h0, tbl[k].es});
      tick();
    end

    // Random traffic over a narrow address window so collisions are frequent.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)),
            $urandom(),
            1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      check($sformatf("rnd%0d bus_a rs1=%0d", n, rs1_addr), bus_a, m_read(rs1_addr));
      check($sformatf("rnd%0d bus_b rs2=%0d", n, rs2_addr), bus_b, m_read(rs2_addr));
      check($sformatf("rnd%0d stall", n), {31'h0, stall},
            {31'h0, m_waiting(rs1_addr) | m_waiting(rs2_addr)});
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
